// File: rtl/pux_si_pkg.sv
// Shared constants and FSM state type for the pux_si_mc operand fetch/dispatch block.
package pux_si_pkg;

  localparam int unsigned ST_OK      = 0;
  localparam int unsigned ST_ILLEGAL = 1;
  localparam int unsigned ST_TIMEOUT = 2;

  // Opcode layout: channel mask occupies the low NCH bits, op field the rest.
  localparam int unsigned OPC_MASK_LSB = 0;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StLoad,
    StExec,
    StStat
  } state_e;

endpackage

// File: rtl/pux_si_opq.sv
// Synchronous opcode FIFO with full/empty flags; read data is combinational from the head slot.
module pux_si_opq #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  // Extra MSB on each pointer distinguishes full from empty.
  logic [PtrW:0]      wr_q, rd_q;
  logic [Width-1:0]   mem_q [Depth];
  logic               do_push, do_pop;

  always_comb begin
    empty_o = (wr_q == rd_q);
    full_o  = (wr_q[PtrW] != rd_q[PtrW]) && (wr_q[PtrW-1:0] == rd_q[PtrW-1:0]);
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    data_o  = mem_q[rd_q[PtrW-1:0]];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[PtrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/pux_si_mc.sv
// Multi-channel PUX stream interface: queues opcodes, loads operand buffers, runs the core,
// reports status. Define PUX_SI_TIMEOUT_EN to build the EXEC watchdog (limit TMO cycles).
module pux_si_mc
  import pux_si_pkg::*;
#(
  parameter int unsigned OPCW      = 8,
  parameter int unsigned DATAW     = 16,
  parameter int unsigned NCH       = 3,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned OPQ_DEPTH = 4,
  parameter int unsigned STATUSW   = 2,
  parameter int unsigned TMO       = 1024,
  localparam int unsigned CHW      = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                 axis_clk,
  input  logic                 axis_rst,
  input  logic [OPCW-1:0]      axis_opcode_data,
  input  logic                 axis_opcode_valid,
  output logic                 axis_opcode_ready,
  input  logic [NCH*DATAW-1:0] axis_buff_data,
  input  logic [NCH-1:0]       axis_buff_valid,
  output logic [NCH-1:0]       axis_buff_ready,
  output logic [STATUSW-1:0]   axis_status_data,
  output logic                 axis_status_valid,
  input  logic                 axis_status_ready,
  output logic                 stream_request,
  output logic [NCH-1:0]       stream_mask,
  output logic                 core_start,
  output logic [OPCW-NCH-1:0]  core_op,
  output logic [NCH-1:0]       core_mask,
  input  logic                 core_done,
  input  logic [CHW-1:0]       core_rd_ch,
  input  logic [AW-1:0]        core_rd_addr,
  output logic [DATAW-1:0]     core_rd_data
);

  localparam int unsigned OPW  = OPCW - NCH;
  localparam int unsigned CntW = AW + 1;

  typedef logic [CntW-1:0] cnt_t;

  state_e              state_q, state_d;
  logic [OPW-1:0]      op_q, op_d;
  logic [NCH-1:0]      mask_q, mask_d;
  logic [STATUSW-1:0]  stat_q, stat_d;
  logic                start_q, start_d;
  cnt_t                cnt_q [NCH];
  cnt_t                cnt_d [NCH];
  logic [DATAW-1:0]    mem_q [NCH][DEPTH];
  logic [DATAW-1:0]    rd_data_q;

  logic [OPCW-1:0]     q_data;
  logic                q_full, q_empty, q_pop;
  logic [NCH-1:0]      buff_ready, hs;
  logic                all_full;

  pux_si_opq #(
    .Depth (OPQ_DEPTH),
    .Width (OPCW)
  ) u_opq (
    .clk_i   (axis_clk),
    .rst_i   (axis_rst),
    .push_i  (axis_opcode_valid),
    .data_i  (axis_opcode_data),
    .pop_i   (q_pop),
    .data_o  (q_data),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

`ifdef PUX_SI_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TMO + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;

  // Counts EXEC cycles; zero in the core_start cycle.
  always_comb begin
    tmo_d = '0;
    if (state_q == StExec) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO;
`endif

  always_comb begin
    all_full = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      buff_ready[i] = (state_q == StLoad) && mask_q[i] && (cnt_q[i] < cnt_t'(DEPTH));
      hs[i]         = buff_ready[i] && axis_buff_valid[i];
      if (mask_q[i] && (cnt_q[i] != cnt_t'(DEPTH))) all_full = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mask_d  = mask_q;
    stat_d  = stat_q;
    start_d = 1'b0;
    q_pop   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = hs[i] ? cnt_q[i] + cnt_t'(1) : cnt_q[i];
    end

    unique case (state_q)
      StIdle: begin
        if (!q_empty) begin
          q_pop  = 1'b1;
          op_d   = q_data[OPCW-1:NCH];
          mask_d = q_data[NCH-1:OPC_MASK_LSB];
          if (&q_data[OPCW-1:NCH]) begin
            stat_d  = STATUSW'(ST_ILLEGAL);
            state_d = StStat;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        for (int i = 0; i < NCH; i++) cnt_d[i] = '0;
        if (mask_q != '0) begin
          state_d = StLoad;
        end else begin
          state_d = StExec;
          start_d = 1'b1;
        end
      end
      StLoad: begin
        if (all_full) begin
          state_d = StExec;
          start_d = 1'b1;
        end
      end
      StExec: begin
        if (core_done) begin
          stat_d  = STATUSW'(ST_OK);
          state_d = StStat;
        end
`ifdef PUX_SI_TIMEOUT_EN
        else if (tmo_q == TmoW'(TMO - 1)) begin
          stat_d  = STATUSW'(ST_TIMEOUT);
          state_d = StStat;
        end
`endif
      end
      StStat: begin
        if (axis_status_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      mask_q  <= '0;
      stat_q  <= '0;
      start_q <= 1'b0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      stat_q  <= stat_d;
      start_q <= start_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Buffer contents survive reset.
  always_ff @(posedge axis_clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (hs[i]) mem_q[i][cnt_q[i][AW-1:0]] <= axis_buff_data[i*DATAW +: DATAW];
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      rd_data_q <= '0;
    end else if (32'(core_rd_ch) < NCH) begin
      rd_data_q <= mem_q[core_rd_ch][core_rd_addr];
    end else begin
      rd_data_q <= '0;
    end
  end

  always_comb begin
    axis_opcode_ready = !q_full;
    axis_buff_ready   = buff_ready;
    axis_status_valid = (state_q == StStat);
    axis_status_data  = axis_status_valid ? stat_q : '0;
    stream_request    = (state_q == StReq);
    stream_mask       = stream_request ? mask_q : '0;
    core_start        = start_q;
    core_op           = (state_q != StIdle) ? op_q : '0;
    core_mask         = (state_q != StIdle) ? mask_q : '0;
    core_rd_data      = rd_data_q;
  end

endmodule

// File: tb/tb_pux_si_mc.sv
// Scoreboard bench for pux_si_mc: directed scenarios plus a randomized opcode stream.
module tb_pux_si_mc;

  localparam int OPCW  = 8;
  localparam int DATAW = 16;
  localparam int NCH   = 3;
  localparam int DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 axis_rst = 1'b1;
  logic [OPCW-1:0]      axis_opcode_data = '0;
  logic                 axis_opcode_valid = 1'b0;
  logic                 axis_opcode_ready;
  logic [NCH*DATAW-1:0] axis_buff_data = '0;
  logic [NCH-1:0]       axis_buff_valid = '0;
  logic [NCH-1:0]       axis_buff_ready;
  logic [1:0]           axis_status_data;
  logic                 axis_status_valid;
  logic                 axis_status_ready = 1'b0;
  logic                 stream_request;
  logic [NCH-1:0]       stream_mask;
  logic                 core_start;
  logic [OPCW-NCH-1:0]  core_op;
  logic [NCH-1:0]       core_mask;
  logic                 core_done = 1'b0;
  logic [1:0]           core_rd_ch = '0;
  logic [2:0]           core_rd_addr = '0;
  logic [DATAW-1:0]     core_rd_data;

  pux_si_mc #(
    .OPCW      (OPCW),
    .DATAW     (DATAW),
    .NCH       (NCH),
    .DEPTH     (DEPTH),
    .OPQ_DEPTH (4),
    .STATUSW   (2),
    .TMO       (1024)
  ) dut (
    .axis_clk          (clk),
    .axis_rst          (axis_rst),
    .axis_opcode_data  (axis_opcode_data),
    .axis_opcode_valid (axis_opcode_valid),
    .axis_opcode_ready (axis_opcode_ready),
    .axis_buff_data    (axis_buff_data),
    .axis_buff_valid   (axis_buff_valid),
    .axis_buff_ready   (axis_buff_ready),
    .axis_status_data  (axis_status_data),
    .axis_status_valid (axis_status_valid),
    .axis_status_ready (axis_status_ready),
    .stream_request    (stream_request),
    .stream_mask       (stream_mask),
    .core_start        (core_start),
    .core_op           (core_op),
    .core_mask         (core_mask),
    .core_done         (core_done),
    .core_rd_ch        (core_rd_ch),
    .core_rd_addr      (core_rd_addr),
    .core_rd_data      (core_rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  int             exp_status[$];
  int             exp_req[$];
  int             exp_core[$];
  logic [DATAW-1:0] model_mem [NCH][DEPTH];
  int             hs_cnt [NCH];
  bit [NCH-1:0]   en = '0;
  bit [NCH-1:0]   cur_mask = '0;
  int             hs_cyc, req_cyc, start_cyc;
  int             n_req = 0, n_start = 0, n_status = 0;
  int             st_mode = 1;  // 0: ready low, 1: ready high, 2: random

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_opc_ready"}, axis_opcode_ready, 1);
    chk({tag, "_buff_ready"}, axis_buff_ready, 0);
    chk({tag, "_st_valid"}, axis_status_valid, 0);
    chk({tag, "_st_data"}, axis_status_data, 0);
    chk({tag, "_req"}, {stream_request, stream_mask}, 0);
    chk({tag, "_core"}, {core_start, core_op, core_mask}, 0);
    chk({tag, "_rd_data"}, core_rd_data, 0);
  endtask

  always begin
    @(posedge clk); #1;
    if (st_mode == 2) axis_status_ready = ($urandom % 3) != 0;
    else              axis_status_ready = (st_mode == 1);
  end

  // Operand streams: per-channel random stalls, model records accepted words.
  always begin
    @(negedge clk);
    if (stream_request) begin
      n_req++;
      req_cyc = cyc;
      if (exp_req.size() == 0) chk("req_expected", 0, 1);
      else chk("req_mask", stream_mask, exp_req.pop_front());
      cur_mask = stream_mask;
      en = stream_mask;
      for (int i = 0; i < NCH; i++) hs_cnt[i] = 0;
    end
    for (int i = 0; i < NCH; i++) begin
      if (axis_buff_ready[i]) begin
        chk("ready_legal", cur_mask[i] && hs_cnt[i] < DEPTH, 1);
        if (axis_buff_valid[i]) begin
          model_mem[i][hs_cnt[i]] = axis_buff_data[i*DATAW +: DATAW];
          hs_cnt[i]++;
          if (hs_cnt[i] >= DEPTH) en[i] = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < NCH; i++) begin
      axis_buff_valid[i] = en[i] && (($urandom % 4) != 0);
      axis_buff_data[i*DATAW +: DATAW] = DATAW'($urandom);
    end
  end

  // Core model: checks dispatch, reads buffers back, then completes.
  always begin
    int e, ch, a;
    logic [NCH-1:0] em;
    logic [DATAW-1:0] want;
    @(negedge clk);
    if (core_start) begin
      n_start++;
      start_cyc = cyc;
      em = '0;
      if (exp_core.size() == 0) begin
        chk("start_expected", 0, 1);
      end else begin
        e = exp_core.pop_front();
        em = NCH'(e);
        chk("core_op", core_op, e >> 8);
        chk("core_mask", core_mask, em);
        for (int i = 0; i < NCH; i++) chk("load_count", hs_cnt[i], em[i] ? DEPTH : 0);
      end
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        a = $urandom % DEPTH;
        if (k == 0 && em[1]) begin
          ch = 1; a = 5;
        end else if (em != '0 && ($urandom % 4) != 0) begin
          ch = $urandom % NCH;
          while (!em[ch]) ch = (ch + 1) % NCH;
        end else begin
          ch = 3;
        end
        core_rd_ch = 2'(ch);
        core_rd_addr = 3'(a);
        @(posedge clk); @(negedge clk);
        if (k == 0) chk("start_pulse", core_start, 0);
        want = (ch < NCH) ? model_mem[ch][a] : '0;
        chk("rd_data", core_rd_data, want);
      end
      repeat ($urandom % 4) @(posedge clk);
      @(posedge clk); #1; core_done = 1'b1;
      @(posedge clk); #1; core_done = 1'b0;
    end
  end

  // Status monitor
  always begin
    logic [1:0] prev;
    bit held;
    @(negedge clk);
    if (axis_status_valid) begin
      if (held) chk("status_stable", axis_status_data, prev);
      if (axis_status_ready) begin
        n_status++;
        if (exp_status.size() == 0) chk("status_expected", 0, 1);
        else chk("status", axis_status_data, exp_status.pop_front());
        held = 0;
      end else begin
        held = 1;
        prev = axis_status_data;
      end
    end else begin
      held = 0;
    end
  end

  task automatic send_op(input logic [7:0] opc, input int bound, output bit ok);
    int op, m;
    ok = 0;
    @(posedge clk); #1;
    axis_opcode_valid = 1'b1;
    axis_opcode_data = opc;
    for (int k = 0; k < bound && !ok; k++) begin
      @(negedge clk);
      if (axis_opcode_ready) begin
        ok = 1;
        hs_cyc = cyc;
        op = int'(opc) >> NCH;
        m = int'(opc) % (1 << NCH);
        if (op == (1 << (OPCW - NCH)) - 1) begin
          exp_status.push_back(1);
        end else begin
          exp_status.push_back(0);
          exp_req.push_back(m);
          exp_core.push_back((op << 8) | m);
        end
      end
      @(posedge clk); #1;
    end
    axis_opcode_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int k = 0;
    while ((exp_status.size() != 0 || exp_req.size() != 0 || exp_core.size() != 0) && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (k >= bound) chk("drain_timeout", 0, 1);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    bit ok;
    int base_req, base_start, base_status, k;
    logic [7:0] opc;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    axis_rst = 1'b0;

    // Minimum latency with mask 0
    send_op(8'h10, 50, ok);
    chk("lat_accept", ok, 1);
    wait_drain(200);
    chk("lat_req", req_cyc - hs_cyc, 2);
    chk("lat_start", start_cyc - hs_cyc, 3);

    // Full three-channel load
    st_mode = 2;
    send_op(8'h17, 50, ok);
    chk("load_accept", ok, 1);
    wait_drain(500);

    // Illegal opcode followed by a normal one
    base_req = n_req; base_start = n_start;
    send_op(8'hFF, 50, ok);
    send_op(8'h0B, 50, ok);
    wait_drain(500);
    chk("illegal_req_count", n_req - base_req, 1);
    chk("illegal_start_count", n_start - base_start, 1);

    // Queue fill with status held off
    st_mode = 0;
    base_status = n_status;
    for (int i = 1; i <= 5; i++) begin
      send_op(8'(8 * i), 20, ok);
      chk("opq_accept", ok, 1);
    end
    send_op(8'h30, 20, ok);
    chk("opq_stall", ok, 0);
    @(negedge clk);
    chk("opq_ready_low", axis_opcode_ready, 0);
    chk("opq_no_status", n_status - base_status, 0);
    st_mode = 1;
    send_op(8'h30, 100, ok);
    chk("opq_sixth", ok, 1);
    wait_drain(500);
    chk("opq_status_count", n_status - base_status, 6);

    // Reset in the middle of LOAD
    send_op(8'h17, 50, ok);
    k = 0;
    while (hs_cnt[0] < 3 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("rst_reach_load", hs_cnt[0] >= 3, 1);
    #1;
    axis_rst = 1'b1;
    en = '0;
    #1;
    check_reset_outputs("rst_mid");
    exp_status.delete();
    exp_req.delete();
    exp_core.delete();
    base_status = n_status;
    repeat (2) @(posedge clk);
    #1;
    axis_rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("rst_no_status", n_status - base_status, 0);
    chk("rst_opc_ready", axis_opcode_ready, 1);

    // Randomized opcode stream
    st_mode = 2;
    for (int i = 0; i < 16; i++) begin
      opc = 8'($urandom);
      if (($urandom % 5) == 0) opc = opc | 8'hF8;
      send_op(opc, 600, ok);
      chk("rand_accept", ok, 1);
    end
    wait_drain(4000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
